// File: rtl/branch_resolve.sv
// Decode-stage branch resolution: evaluates condition codes against stored flags,
// stalls across flag hazards, and issues a registered redirect/flush pulse to fetch.
module branch_resolve #(
    parameter int PC_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       flags,
    input  logic             flag_wr_pending,
    input  logic             br_valid,
    input  logic             br_reg,
    input  logic [2:0]       cond,
    input  logic [PC_W-1:0]  pc_plus2,
    input  logic [8:0]       imm9,
    input  logic [PC_W-1:0]  rs_val,
    output logic             stall,
    output logic             redirect,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t state, next_state;

    logic flag_z, flag_v, flag_n;
    logic taken;
    logic resolvable;
    logic stall_c;
    logic load_target;
    logic [PC_W-1:0] offset;
    logic [PC_W-1:0] target;

    assign flag_z = flags[0];
    assign flag_v = flags[1];
    assign flag_n = flags[2];

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        taken = 1'b0;
        case (cond)
            3'b000: taken = ~flag_z;
            3'b001: taken = flag_z;
            3'b010: taken = ~flag_z & ~flag_n;
            3'b011: taken = flag_n;
            3'b100: taken = flag_z | (~flag_z & ~flag_n);
            3'b101: taken = flag_n | flag_z;
            3'b110: taken = flag_v;
            3'b111: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // The unconditional branch does not depend on flags, so an in-flight flag write cannot delay it.
    assign resolvable = (cond == 3'b111) || !flag_wr_pending;

    assign offset = {{(PC_W-9){imm9[8]}}, imm9} << 1;
    assign target = br_reg ? rs_val : (pc_plus2 + offset);

    always_comb begin
        next_state  = state;
        stall_c     = 1'b0;
        load_target = 1'b0;
        case (state)
            IDLE, WAIT: begin
                next_state = IDLE;
                if (br_valid) begin
                    if (!resolvable) begin
                        next_state = WAIT;
                        stall_c    = 1'b1;
                    end else if (taken) begin
                        next_state  = REDIR;
                        stall_c     = 1'b1;
                        load_target = 1'b1;
                    end
                end
            end
            REDIR: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            redirect_pc <= '0;
            taken_cnt   <= '0;
        end else begin
            state <= next_state;
            if (load_target) begin
                redirect_pc <= target;
            end
            if (state == REDIR) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
        end
    end

    // stall is combinational, so it is gated with reset to stay low while reset is held.
    assign stall    = rst & stall_c;
    assign redirect = (state == REDIR);
    assign flush    = redirect;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve; a narrow-counter copy covers wrap.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  flags;
    logic        flag_wr_pending;
    logic        br_valid;
    logic        br_reg;
    logic [2:0]  cond;
    logic [15:0] pc_plus2;
    logic [8:0]  imm9;
    logic [15:0] rs_val;

    logic        stall, redirect, flush;
    logic [15:0] redirect_pc;
    logic [15:0] taken_cnt;

    logic        s_stall, s_redirect, s_flush;
    logic [15:0] s_redirect_pc;
    logic [3:0]  s_taken_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_cnt = '0;

    always #5 clk = ~clk;

    branch_resolve dut (
        .clk(clk), .rst(rst), .flags(flags), .flag_wr_pending(flag_wr_pending),
        .br_valid(br_valid), .br_reg(br_reg), .cond(cond), .pc_plus2(pc_plus2),
        .imm9(imm9), .rs_val(rs_val), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .flush(flush), .taken_cnt(taken_cnt)
    );

    branch_resolve #(.PC_W(16), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .flags(flags), .flag_wr_pending(flag_wr_pending),
        .br_valid(br_valid), .br_reg(br_reg), .cond(cond), .pc_plus2(pc_plus2),
        .imm9(imm9), .rs_val(rs_val), .stall(s_stall), .redirect(s_redirect),
        .redirect_pc(s_redirect_pc), .flush(s_flush), .taken_cnt(s_taken_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic r, input logic [2:0] c, input logic [2:0] f,
                         input logic p, input logic [15:0] pc, input logic [8:0] im,
                         input logic [15:0] rs);
        br_valid = v; br_reg = r; cond = c; flags = f;
        flag_wr_pending = p; pc_plus2 = pc; imm9 = im; rs_val = rs;
    endtask

    // Move to the next falling edge, then let combinational outputs settle.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    function automatic logic model_taken(input logic [2:0] c, input logic [2:0] f);
        logic z, v, n;
        z = f[0]; v = f[1]; n = f[2];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !(z || n);
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return z || n;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    initial begin
        logic t;
        rst = 1'b0;
        drive(1'b1, 1'b0, 3'b111, 3'b000, 1'b0, 16'h0010, 9'h000, 16'h0000);

        // Reset holds outputs low even with a pending unconditional branch.
        next_cycle(); next_cycle(); #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_redirect", 32'(redirect), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_cnt", 32'(taken_cnt), 32'd0);
        check("rst_pc", 32'(redirect_pc), 32'd0);

        next_cycle(); rst = 1'b1; #1;
        check("rel_stall", 32'(stall), 32'd1);
        check("rel_redirect0", 32'(redirect), 32'd0);
        next_cycle(); br_valid = 1'b0; #1;
        check("rel_redirect1", 32'(redirect), 32'd1);
        check("rel_flush1", 32'(flush), 32'd1);
        check("rel_stall_redir", 32'(stall), 32'd0);
        check("rel_pc", 32'(redirect_pc), 32'h0010);
        exp_cnt++;
        next_cycle(); #1;
        check("rel_redirect_end", 32'(redirect), 32'd0);
        check("rel_cnt", 32'(taken_cnt), 32'(exp_cnt));

        // EQ taken, B with negative offset.
        drive(1'b1, 1'b0, 3'b001, 3'b001, 1'b0, 16'h0010, 9'h1FE, 16'h0000); #1;
        check("eq_stall", 32'(stall), 32'd1);
        next_cycle(); br_valid = 1'b0; #1;
        check("eq_redirect", 32'(redirect), 32'd1);
        check("eq_pc", 32'(redirect_pc), 32'h000C);
        exp_cnt++;
        next_cycle(); #1;
        check("eq_cnt", 32'(taken_cnt), 32'(exp_cnt));

        // LT with two hazard cycles, then taken.
        drive(1'b1, 1'b0, 3'b011, 3'b000, 1'b1, 16'h0100, 9'h004, 16'h0000); #1;
        check("hz_t_stall0", 32'(stall), 32'd1);
        next_cycle(); #1;
        check("hz_t_stall1", 32'(stall), 32'd1);
        check("hz_t_noredir1", 32'(redirect), 32'd0);
        next_cycle(); flag_wr_pending = 1'b0; flags = 3'b100; #1;
        check("hz_t_stall2", 32'(stall), 32'd1);
        next_cycle(); br_valid = 1'b0; #1;
        check("hz_t_redirect", 32'(redirect), 32'd1);
        check("hz_t_pc", 32'(redirect_pc), 32'h0108);
        exp_cnt++;
        next_cycle(); #1;

        // LT with two hazard cycles, then not taken.
        drive(1'b1, 1'b0, 3'b011, 3'b000, 1'b1, 16'h0200, 9'h004, 16'h0000); #1;
        check("hz_n_stall0", 32'(stall), 32'd1);
        next_cycle(); #1;
        check("hz_n_stall1", 32'(stall), 32'd1);
        next_cycle(); flag_wr_pending = 1'b0; #1;
        check("hz_n_stall2", 32'(stall), 32'd0);
        next_cycle(); br_valid = 1'b0; #1;
        check("hz_n_redirect", 32'(redirect), 32'd0);
        check("hz_n_cnt", 32'(taken_cnt), 32'(exp_cnt));

        // Unconditional branch ignores a pending flag write.
        drive(1'b1, 1'b0, 3'b111, 3'b000, 1'b1, 16'h0300, 9'h000, 16'h0000); #1;
        check("al_pend_stall", 32'(stall), 32'd1);
        next_cycle(); br_valid = 1'b0; #1;
        check("al_pend_redirect", 32'(redirect), 32'd1);
        exp_cnt++;
        next_cycle(); #1;

        // External squash while waiting: no redirect.
        drive(1'b1, 1'b0, 3'b001, 3'b001, 1'b1, 16'h0400, 9'h000, 16'h0000); #1;
        next_cycle(); br_valid = 1'b0; #1;
        check("sq_stall", 32'(stall), 32'd0);
        next_cycle(); #1;
        check("sq_redirect", 32'(redirect), 32'd0);

        // BR target and B target wrap.
        drive(1'b1, 1'b1, 3'b111, 3'b000, 1'b0, 16'h0000, 9'h000, 16'hABCD); #1;
        next_cycle(); br_valid = 1'b0; #1;
        check("br_pc", 32'(redirect_pc), 32'hABCD);
        exp_cnt++;
        next_cycle(); #1;
        drive(1'b1, 1'b0, 3'b111, 3'b000, 1'b0, 16'hFFFE, 9'h002, 16'h0000); #1;
        next_cycle(); br_valid = 1'b0; #1;
        check("wrap_pc", 32'(redirect_pc), 32'h0002);
        exp_cnt++;
        next_cycle(); #1;
        check("wrap_cnt", 32'(taken_cnt), 32'(exp_cnt));

        // All condition codes against all flag combinations.
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                t = model_taken(3'(c), 3'(f));
                drive(1'b1, 1'b1, 3'(c), 3'(f), 1'b0, 16'h0000, 9'h000, 16'(16'h1000 + c * 8 + f)); #1;
                check($sformatf("ex_stall_c%0d_f%0d", c, f), 32'(stall), 32'(t));
                next_cycle(); br_valid = 1'b0; #1;
                check($sformatf("ex_redir_c%0d_f%0d", c, f), 32'(redirect), 32'(t));
                if (t) begin
                    check($sformatf("ex_pc_c%0d_f%0d", c, f), 32'(redirect_pc), 32'(16'h1000 + c * 8 + f));
                    exp_cnt++;
                end
                next_cycle();
            end
        end
        #1;
        check("ex_cnt", 32'(taken_cnt), 32'(exp_cnt));
        check("ex_cnt_small", 32'(s_taken_cnt), 32'(exp_cnt[3:0]));

        // Narrow counter: bring it to all-ones, then one more branch wraps it to zero.
        for (int i = 0; i < 16 && exp_cnt[3:0] != 4'hF; i++) begin
            drive(1'b1, 1'b0, 3'b111, 3'b000, 1'b0, 16'h0000, 9'h000, 16'h0000);
            next_cycle(); br_valid = 1'b0;
            exp_cnt++;
            next_cycle();
        end
        #1;
        check("small_full", 32'(s_taken_cnt), 32'hF);
        drive(1'b1, 1'b0, 3'b111, 3'b000, 1'b0, 16'h0000, 9'h000, 16'h0000);
        next_cycle(); br_valid = 1'b0;
        exp_cnt++;
        next_cycle(); #1;
        check("small_wrap", 32'(s_taken_cnt), 32'h0);
        check("main_cnt", 32'(taken_cnt), 32'(exp_cnt));

        // Reset while waiting on a flag hazard.
        drive(1'b1, 1'b0, 3'b011, 3'b100, 1'b1, 16'h0500, 9'h000, 16'h0000); #1;
        next_cycle(); #1;
        check("rw_stall_pre", 32'(stall), 32'd1);
        rst = 1'b0; #1;
        check("rw_stall_async", 32'(stall), 32'd0);
        check("rw_cnt", 32'(taken_cnt), 32'd0);
        exp_cnt = '0;
        next_cycle(); br_valid = 1'b0; rst = 1'b1;
        next_cycle(); #1;
        check("rw_redirect_post", 32'(redirect), 32'd0);
        drive(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 16'h0600, 9'h001, 16'h0000); #1;
        check("rw_idle_stall", 32'(stall), 32'd1);
        next_cycle(); br_valid = 1'b0; #1;
        check("rw_idle_redirect", 32'(redirect), 32'd1);
        check("rw_idle_pc", 32'(redirect_pc), 32'h0602);

        // Reset during the redirect cycle.
        #2; rst = 1'b0; #1;
        check("rr_redirect", 32'(redirect), 32'd0);
        check("rr_flush", 32'(flush), 32'd0);
        check("rr_pc", 32'(redirect_pc), 32'd0);
        check("rr_cnt", 32'(taken_cnt), 32'd0);
        next_cycle(); rst = 1'b1;
        next_cycle(); #1;
        check("rr_redirect_post", 32'(redirect), 32'd0);
        check("rr_cnt_post", 32'(taken_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Decode-stage branch resolution unit sitting directly downstream of the 3-bit condition flag register (Z, V, N). It evaluates B/BR condition codes against the stored flags and stalls while an EX-stage instruction is still producing flags. It computes the branch target and issues a one-cycle redirect/flush pulse to fetch. It also keeps a wrapping count of taken branches for debug.

## Interface
- PC_W, 16, program counter / register width
- CNT_W, 16, taken-branch counter width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- flags  in  3  stored flags from flag register: [0]=Z, [1]=V, [2]=N
- flag_wr_pending  in  1  instruction currently in EX will write flags at end of this cycle
- br_valid  in  1  instruction in ID is a branch
- br_reg  in  1  1 = BR (target from register), 0 = B (PC-relative)
- cond  in  3  condition code
- pc_plus2  in  PC_W  address of the instruction after the branch
- imm9  in  9  signed word offset for B
- rs_val  in  PC_W  register target for BR
- stall  out  1  hold PC and IF/ID; ID inputs must stay stable while high
- redirect  out  1  one-cycle pulse: load redirect_pc into PC
- redirect_pc  out  PC_W  registered branch target, valid when redirect=1
- flush  out  1  one-cycle pulse, equal to redirect: squash IF/ID
- taken_cnt  out  CNT_W  number of taken branches since reset, wraps

## Operation
- Conditions: 000 NE (Z=0); 001 EQ (Z=1); 010 GT (Z=0 and N=0); 011 LT (N=1); 100 GE (Z=1 or (Z=0 and N=0)); 101 LE (N=1 or Z=1); 110 OV (V=1); 111 always.
- Target: B = pc_plus2 + (sign_extend(imm9) << 1), truncated to PC_W with wrap. BR = rs_val.
- Resolvable: cond=111, or flag_wr_pending=0. Cond 111 never waits.
- FSM states:
  - IDLE: if br_valid=0, stay. If br_valid=1 and not resolvable, go to WAIT with stall=1. If resolvable and taken, latch target, stall=1, go to REDIR. If resolvable and not taken, stall=0, stay IDLE.
  - WAIT: stall=1. Re-check every cycle with the same rules as IDLE. Taken goes to REDIR with stall=1. Not-taken goes to IDLE with stall=0 in that cycle.
  - REDIR: redirect=1, flush=1, stall=0, taken_cnt += 1. Always returns to IDLE. br_valid is ignored in this cycle because the ID slot is being flushed.
- Inputs are not latched during WAIT; upstream holds them stable because stall=1.
- br_valid dropping in WAIT (external squash) returns the FSM to IDLE with no redirect.

## Timing
- Reset (rst=0, async): state=IDLE, stall=0, redirect=0, flush=0, redirect_pc=0, taken_cnt=0. These values hold while rst=0 regardless of inputs.
- stall is combinational from state and inputs. redirect, flush and redirect_pc are driven from registered state and the latched target.
- Taken, no hazard: cycle N stall=1; cycle N+1 redirect=flush=1. Penalty: 2 cycles.
- Not taken, no hazard: zero stall cycles.
- Hazard: each cycle with flag_wr_pending=1 adds one stall cycle. Flags written at the end of that cycle are evaluated in the next cycle.
- taken_cnt wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-WAIT or mid-REDIR: outputs drop immediately, no pending redirect survives.

## Test plan
- Reset values: hold rst=0 with br_valid=1, cond=111 -> stall=redirect=flush=0, taken_cnt=0. Release rst -> redirect pulses on the 2nd cycle.
- EQ taken, B: flags=001, cond=001, pc_plus2=0x0010, imm9=0x1FE (-2) -> stall 1 cycle, then redirect=1 with redirect_pc=0x000C, taken_cnt=1.
- Flag hazard: cond=011, flag_wr_pending=1 for 2 cycles, then flags=100 -> stall high 3 cycles, then redirect. With flags=000 instead -> stall high 2 cycles, no redirect.
- BR and wrap: br_reg=1, rs_val=0xABCD, cond=111 -> redirect_pc=0xABCD. B with pc_plus2=0xFFFE, imm9=0x002 -> redirect_pc=0x0002.
- Exhaustive conditions: all 8 cond values × 8 flag values vs the condition list -> taken/not-taken matches the list exactly. taken_cnt preloaded to 0xFFFF via 65535 branches wraps to 0.
- Reset mid-op: assert rst in WAIT and separately in the REDIR cycle -> redirect deasserts asynchronously, FSM in IDLE after release, taken_cnt=0.
